// File: rtl/sp_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arb_pkg
// Description : Shared helpers for the single-port RAM round-robin arbiter:
//               master-index width and wrap-around increment.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_arb_pkg;

    localparam int c_default_n_masters  = 2;
    localparam int c_default_addr_width = 8;
    localparam int c_default_data_width = 32;

    // Width of a master index; at least one bit so a 1-bit vector is legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next master index after idx, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter_if
// Description : Bundle of master-side and RAM-side signals of the arbiter.
//               'slave' is the arbiter's view, 'master' the environment's.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_ram_arbiter_if #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();

    // Master side
    logic [N_MASTERS-1:0]              m_req_i;
    logic [N_MASTERS*ADDR_WIDTH-1:0]   m_addr_i;
    logic [N_MASTERS-1:0]              m_we_i;
    logic [N_MASTERS*DATA_WIDTH-1:0]   m_wdata_i;
    logic [N_MASTERS*DATA_WIDTH/8-1:0] m_be_i;
    logic [N_MASTERS-1:0]              m_gnt_o;
    logic [N_MASTERS-1:0]              m_rvalid_o;
    logic [DATA_WIDTH-1:0]             m_rdata_o;

    // RAM side
    logic                              mem_req_o;
    logic [ADDR_WIDTH-1:0]             mem_addr_o;
    logic                              mem_we_o;
    logic [DATA_WIDTH-1:0]             mem_wdata_o;
    logic [DATA_WIDTH/8-1:0]           mem_be_o;
    logic                              mem_gnt_i;
    logic                              mem_rvalid_i;
    logic [DATA_WIDTH-1:0]             mem_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_wdata_i, m_be_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_wdata_i, m_be_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o
    );

endinterface
`default_nettype wire

// File: rtl/sp_ram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin select. Picks the first requester
//               at or after ptr, searching upwards with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int N_MASTERS = c_default_n_masters,
    parameter int IDX_W     = idx_w(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]     sel
);

    // One extra bit so ptr+k can exceed N_MASTERS-1 before the wrap.
    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N_MASTERS);

    // Scan from ptr upwards; the first hit wins, sel stays 0 when idle so the
    // request fields default to master 0.
    always_comb begin
        logic [IDX_W:0] v_idx;
        logic           v_found;
        gnt     = '0;
        sel     = '0;
        v_found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            v_idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (v_idx >= c_n) begin
                v_idx = v_idx - c_n;
            end
            if (!v_found && req[v_idx[IDX_W-1:0]]) begin
                v_found                  = 1'b1;
                sel                      = v_idx[IDX_W-1:0];
                gnt[v_idx[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter
// Description : Shares one single-port RAM (req/gnt/rvalid, one-cycle read
//               latency) between N_MASTERS requesters with round-robin
//               priority, and routes each response to the master that owns it.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int N_MASTERS  = c_default_n_masters,
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic             clk,
    input  logic             rst,
    sp_ram_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_w(N_MASTERS);
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } req_t;

    req_t                 w_reqs [N_MASTERS];
    req_t                 w_sel_req;
    logic [N_MASTERS-1:0] w_gnt_oh;
    logic [IDX_W-1:0]     w_sel;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic                 w_any_req;
    logic                 w_accept;
    logic [N_MASTERS-1:0] w_rvalid;

    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_pend;

    // Unpack the flat per-master buses into request records.
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
        assign w_reqs[gi] = '{
            addr:  bus.m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
            we:    bus.m_we_i[gi],
            wdata: bus.m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH],
            be:    bus.m_be_i[gi*BE_W +: BE_W]
        };
    end

    rr_arbiter #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req (bus.m_req_i),
        .ptr (r_ptr),
        .gnt (w_gnt_oh),
        .sel (w_sel)
    );

    assign w_any_req = |bus.m_req_i;
    assign w_accept  = w_any_req & bus.mem_gnt_i;
    assign w_sel_req = w_reqs[w_sel];
    assign w_ptr_nxt = IDX_W'(wrap_inc(int'(w_sel), N_MASTERS));

    // Request path is purely combinational: no added latency to the RAM.
    assign bus.mem_req_o   = w_any_req;
    assign bus.mem_addr_o  = w_sel_req.addr;
    assign bus.mem_we_o    = w_sel_req.we;
    assign bus.mem_wdata_o = w_sel_req.wdata;
    assign bus.mem_be_o    = w_sel_req.be;
    assign bus.m_gnt_o     = w_gnt_oh & {N_MASTERS{bus.mem_gnt_i}};

    // Read data is shared; only the owner's rvalid qualifies it.
    assign bus.m_rdata_o   = bus.mem_rdata_i;
    assign bus.m_rvalid_o  = w_rvalid;

    // Steer the RAM response to whichever master was accepted last cycle.
    always_comb begin
        w_rvalid = '0;
        if (bus.mem_rvalid_i && r_pend) begin
            w_rvalid[r_owner] = 1'b1;
        end
    end

    // Advance priority past the winner and remember who owns the response;
    // the RAM answers every accept next cycle, so a single slot suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_pend  <= 1'b0;
        end else if (w_accept) begin
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_sel;
            r_pend  <= 1'b1;
        end else begin
            r_pend  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_arbiter
// Description : Bench for sp_ram_arbiter with a 2-master and a 3-master
//               instance, each fronting a small behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clr = 1'b1;
    always #5 clk = ~clk;

    sp_ram_arbiter_if #(.N_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
    sp_ram_arbiter_if #(.N_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    sp_ram_arbiter #(.N_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2));
    sp_ram_arbiter #(.N_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3));

    // ---------------- behavioural RAMs (answer every accept next cycle) ----
    logic [31:0] ram [2][64];
    logic        ram_rv [2];
    logic [31:0] ram_rd [2];

    assign bus2.mem_rvalid_i = ram_rv[0];
    assign bus2.mem_rdata_i  = ram_rd[0];
    assign bus3.mem_rvalid_i = ram_rv[1];
    assign bus3.mem_rdata_i  = ram_rd[1];

    always @(posedge clk) begin
        ram_rv[0] <= bus2.mem_req_o & bus2.mem_gnt_i;
        ram_rv[1] <= bus3.mem_req_o & bus3.mem_gnt_i;
        if (ram_clr) begin
            for (int w = 0; w < 64; w++) begin
                ram[0][w] <= '0;
                ram[1][w] <= '0;
            end
        end else begin
            if (bus2.mem_req_o && bus2.mem_gnt_i) begin
                if (bus2.mem_we_o) begin
                    for (int b = 0; b < BW; b++)
                        if (bus2.mem_be_o[b]) ram[0][bus2.mem_addr_o[7:2]][8*b +: 8] <= bus2.mem_wdata_o[8*b +: 8];
                end else ram_rd[0] <= ram[0][bus2.mem_addr_o[7:2]];
            end
            if (bus3.mem_req_o && bus3.mem_gnt_i) begin
                if (bus3.mem_we_o) begin
                    for (int b = 0; b < BW; b++)
                        if (bus3.mem_be_o[b]) ram[1][bus3.mem_addr_o[7:2]][8*b +: 8] <= bus3.mem_wdata_o[8*b +: 8];
                end else ram_rd[1] <= ram[1][bus3.mem_addr_o[7:2]];
            end
        end
    end

    // ---------------- stimulus state (index 0: N=2, index 1: N=3) ----------
    logic [2:0]  s_req   [2];
    logic [2:0]  s_we    [2];
    logic [7:0]  s_addr  [2][3];
    logic [31:0] s_wdata [2][3];
    logic [3:0]  s_be    [2][3];
    logic        s_gnt   [2];
    logic        s_rst;

    // sampled DUT outputs
    logic [2:0]  a_gnt [2];
    logic [2:0]  a_rv  [2];
    logic        a_mreq [2];
    logic [7:0]  a_addr [2];
    logic        a_we [2];
    logic [31:0] a_wdata [2];
    logic [3:0]  a_be [2];
    logic [31:0] a_rdata [2];

    // reference model: priority pointer, response slot, expected memory
    int          m_ptr  [2];
    int          m_own  [2];
    bit          m_pend [2];
    bit          m_rd   [2];
    logic [31:0] m_rdat [2];
    int          m_gsel [2];
    int          wait_cnt [2][3];
    logic [31:0] ref_mem [2][64];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    function automatic int nm(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    // First requester at or after ptr, wrapping; -1 when none.
    function automatic int pick(input int n, input logic [2:0] req, input int ptr);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (ptr + k) % n;
            if (((req >> j) & 3'd1) != 3'd0) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        rst               = s_rst;
        bus2.m_req_i      = s_req[0][1:0];
        bus2.m_we_i       = s_we[0][1:0];
        bus2.m_addr_i     = {s_addr[0][1], s_addr[0][0]};
        bus2.m_wdata_i    = {s_wdata[0][1], s_wdata[0][0]};
        bus2.m_be_i       = {s_be[0][1], s_be[0][0]};
        bus2.mem_gnt_i    = s_gnt[0];
        bus3.m_req_i      = s_req[1];
        bus3.m_we_i       = s_we[1];
        bus3.m_addr_i     = {s_addr[1][2], s_addr[1][1], s_addr[1][0]};
        bus3.m_wdata_i    = {s_wdata[1][2], s_wdata[1][1], s_wdata[1][0]};
        bus3.m_be_i       = {s_be[1][2], s_be[1][1], s_be[1][0]};
        bus3.mem_gnt_i    = s_gnt[1];
    endtask

    task automatic sample();
        a_gnt[0] = {1'b0, bus2.m_gnt_o};  a_gnt[1] = bus3.m_gnt_o;
        a_rv[0]  = {1'b0, bus2.m_rvalid_o}; a_rv[1] = bus3.m_rvalid_o;
        a_mreq[0] = bus2.mem_req_o;  a_mreq[1] = bus3.mem_req_o;
        a_addr[0] = bus2.mem_addr_o; a_addr[1] = bus3.mem_addr_o;
        a_we[0]   = bus2.mem_we_o;   a_we[1]   = bus3.mem_we_o;
        a_wdata[0] = bus2.mem_wdata_o; a_wdata[1] = bus3.mem_wdata_o;
        a_be[0]   = bus2.mem_be_o;   a_be[1]   = bus3.mem_be_o;
        a_rdata[0] = bus2.m_rdata_o; a_rdata[1] = bus3.m_rdata_o;
    endtask

    task automatic model_check(input int i);
        int n, sel, s0;
        logic [2:0] eg, erv;
        n   = nm(i);
        sel = pick(n, s_req[i], m_ptr[i]);
        s0  = (sel < 0) ? 0 : sel;
        eg  = '0;
        if (sel >= 0 && s_gnt[i]) eg = 3'(1 << sel);
        erv = '0;
        if (m_pend[i]) erv = 3'(1 << m_own[i]);
        chk($sformatf("n%0d gnt", n),      32'(a_gnt[i]),   32'(eg));
        chk($sformatf("n%0d mem_req", n),  32'(a_mreq[i]),  32'(sel >= 0));
        chk($sformatf("n%0d mem_addr", n), 32'(a_addr[i]),  32'(s_addr[i][s0]));
        chk($sformatf("n%0d mem_we", n),   32'(a_we[i]),    32'(s_we[i][s0]));
        chk($sformatf("n%0d mem_wdata", n), a_wdata[i],     s_wdata[i][s0]);
        chk($sformatf("n%0d mem_be", n),   32'(a_be[i]),    32'(s_be[i][s0]));
        chk($sformatf("n%0d rvalid", n),   32'(a_rv[i]),    32'(erv));
        if (m_pend[i] && m_rd[i])
            chk($sformatf("n%0d rdata", n), a_rdata[i], m_rdat[i]);
    endtask

    task automatic model_update(input int i);
        int n, sel, w;
        bit acc;
        n   = nm(i);
        sel = pick(n, s_req[i], m_ptr[i]);
        acc = (sel >= 0) && s_gnt[i];
        m_gsel[i] = acc ? sel : -1;
        if (acc) begin
            w = int'(s_addr[i][sel][7:2]);
            if (s_we[i][sel]) begin
                for (int b = 0; b < BW; b++)
                    if (s_be[i][sel][b]) ref_mem[i][w][8*b +: 8] = s_wdata[i][sel][8*b +: 8];
            end else m_rdat[i] = ref_mem[i][w];
            // fairness: a waiting master sees at most n-1 other accepts
            for (int j = 0; j < n; j++) begin
                if (s_req[i][j] && j != sel && !s_rst) begin
                    wait_cnt[i][j]++;
                    chk($sformatf("n%0d fair m%0d", n, j), 32'(wait_cnt[i][j] <= n - 1), 32'd1);
                end
            end
        end
        for (int j = 0; j < n; j++)
            if (!s_req[i][j] || s_rst || (acc && j == sel)) wait_cnt[i][j] = 0;
        if (s_rst) begin
            m_ptr[i] = 0; m_own[i] = 0; m_pend[i] = 1'b0;
        end else if (acc) begin
            m_ptr[i] = (sel + 1) % n; m_own[i] = sel; m_pend[i] = 1'b1;
            m_rd[i] = !s_we[i][sel];
        end else begin
            m_pend[i] = 1'b0;
        end
    endtask

    // One clock: drive after the edge, check on the falling edge, advance model.
    task automatic step();
        drive();
        @(negedge clk);
        sample();
        model_check(0);
        model_check(1);
        @(posedge clk);
        model_update(0);
        model_update(1);
        cyc++;
        #1;
    endtask

    task automatic set_m(input int i, input int j, input logic rq, input logic we,
                         input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        s_req[i][j] = rq; s_we[i][j] = we; s_addr[i][j] = a; s_wdata[i][j] = d; s_be[i][j] = be;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) set_m(i, j, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
            s_gnt[i] = 1'b1;
        end
        s_rst = 1'b0;
    endtask

    // ---------------- directed table for the 2-master instance -------------
    typedef struct {
        logic        rst;
        logic        mgnt;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  a0, a1;
        logic [31:0] d0;
        logic [3:0]  be0;
        logic [1:0]  e_gnt;
        logic        e_mreq;
        logic [1:0]  e_rv;
        logic        c_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic r, input logic g, input logic [1:0] rq, input logic [1:0] we,
                                input logic [7:0] a0, input logic [7:0] a1, input logic [31:0] d0,
                                input logic [3:0] be0, input logic [1:0] eg, input logic em,
                                input logic [1:0] erv, input logic crd, input logic [31:0] erd);
        vec_t v;
        v.rst = r; v.mgnt = g; v.req = rq; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.be0 = be0;
        v.e_gnt = eg; v.e_mreq = em; v.e_rv = erv; v.c_rd = crd; v.e_rd = erd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded budget", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rot [4];

        tbl[0]  = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        4'h0, 2'b00, 0, 2'b00, 0, 32'h0);
        tbl[1]  = mk(0, 1, 2'b01, 2'b01, 8'h04, 8'h00, 32'hDEADBEEF, 4'hF, 2'b01, 1, 2'b00, 0, 32'h0);
        tbl[2]  = mk(0, 1, 2'b01, 2'b00, 8'h04, 8'h00, 32'h0,        4'hF, 2'b01, 1, 2'b01, 0, 32'h0);
        tbl[3]  = mk(0, 1, 2'b00, 2'b00, 8'h04, 8'h00, 32'h0,        4'hF, 2'b00, 0, 2'b01, 1, 32'hDEADBEEF);
        tbl[4]  = mk(0, 1, 2'b10, 2'b00, 8'h00, 8'h08, 32'h0,        4'hF, 2'b10, 1, 2'b00, 0, 32'h0);
        for (int k = 0; k < 6; k++)
            tbl[5+k] = mk(0, 1, 2'b11, 2'b00, 8'h10, 8'h14, 32'h0, 4'hF,
                          (k % 2 == 1) ? 2'b10 : 2'b01, 1, (k % 2 == 1) ? 2'b01 : 2'b10, 0, 32'h0);
        tbl[11] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 4'hF, 2'b00, 0, 2'b10, 0, 32'h0);
        for (int k = 0; k < 3; k++)
            tbl[12+k] = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h18, 32'h0, 4'hF, 2'b00, 1, 2'b00, 0, 32'h0);
        tbl[15] = mk(0, 1, 2'b10, 2'b00, 8'h00, 8'h18, 32'h0, 4'hF, 2'b10, 1, 2'b00, 0, 32'h0);
        tbl[16] = mk(0, 1, 2'b11, 2'b00, 8'h10, 8'h18, 32'h0, 4'hF, 2'b01, 1, 2'b10, 0, 32'h0);
        tbl[17] = mk(1, 1, 2'b10, 2'b00, 8'h10, 8'h1C, 32'h0, 4'hF, 2'b10, 1, 2'b01, 0, 32'h0);
        tbl[18] = mk(0, 1, 2'b11, 2'b00, 8'h10, 8'h1C, 32'h0, 4'hF, 2'b01, 1, 2'b00, 0, 32'h0);
        tbl[19] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 4'hF, 2'b00, 0, 2'b01, 0, 32'h0);

        // reset with RAM clear, model starts from its reset state
        idle_all();
        s_rst = 1'b1;
        drive();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0; m_own[i] = 0; m_pend[i] = 1'b0; m_rd[i] = 1'b0; m_rdat[i] = '0; m_gsel[i] = -1;
            for (int j = 0; j < 3; j++) wait_cnt[i][j] = 0;
            for (int w = 0; w < 64; w++) ref_mem[i][w] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        s_rst   = 1'b0;
        ram_clr = 1'b0;

        // directed table on the 2-master instance
        for (int v = 0; v < 20; v++) begin
            idle_all();
            s_rst    = tbl[v].rst;
            s_gnt[0] = tbl[v].mgnt;
            set_m(0, 0, tbl[v].req[0], tbl[v].we[0], tbl[v].a0, tbl[v].d0, tbl[v].be0);
            set_m(0, 1, tbl[v].req[1], tbl[v].we[1], tbl[v].a1, 32'h0, 4'hF);
            step();
            chk($sformatf("tbl%0d gnt", v),     32'(a_gnt[0]),  32'(tbl[v].e_gnt));
            chk($sformatf("tbl%0d mem_req", v), 32'(a_mreq[0]), 32'(tbl[v].e_mreq));
            chk($sformatf("tbl%0d rvalid", v),  32'(a_rv[0]),   32'(tbl[v].e_rv));
            if (tbl[v].c_rd) chk($sformatf("tbl%0d rdata", v), a_rdata[0], tbl[v].e_rd);
        end

        // byte enables on the 3-master instance
        idle_all();
        set_m(1, 2, 1'b1, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF);
        step();
        chk("be wr_full gnt", 32'(a_gnt[1]), 32'b100);
        set_m(1, 2, 1'b1, 1'b1, 8'h20, 32'h11223344, 4'h3);
        step();
        chk("be wr_part gnt", 32'(a_gnt[1]), 32'b100);
        chk("be wr_part rvalid", 32'(a_rv[1]), 32'b100);
        idle_all();
        set_m(1, 0, 1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
        step();
        chk("be rd gnt", 32'(a_gnt[1]), 32'b001);
        idle_all();
        step();
        chk("be rd rvalid", 32'(a_rv[1]), 32'b001);
        chk("be rd rdata", a_rdata[1], 32'hFFFF3344);

        // 3-master rotation with all requesting; pointer sits at 1 here
        rot[0] = 3'b010; rot[1] = 3'b100; rot[2] = 3'b001; rot[3] = 3'b010;
        for (int j = 0; j < 3; j++) set_m(1, j, 1'b1, 1'b0, 8'(4 * j), 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rot3 gnt%0d", k), 32'(a_gnt[1]), 32'(rot[k]));
        end

        // randomized traffic: requests held until granted, sporadic stalls/resets
        idle_all();
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < nm(i); j++) begin
                    if (!s_req[i][j] || m_gsel[i] == j) begin
                        set_m(i, j, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                              8'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
                    end
                end
                s_gnt[i] = ($urandom_range(0, 3) != 0);
            end
            s_rst = ($urandom_range(0, 39) == 0);
        end
        idle_all();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
